// File: rtl/ifu_pkg.sv
// Shared widths, PC step and the fetch-queue entry type for the instruction fetch unit.
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous in-order FIFO. Flush beats push and pop.
// There is no bypass, so a push into a full queue is dropped even when a pop happens.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Payload storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC and halt, reads the ROM, and queues words for issue.
// Optional IFU_ZERO_HALT_EN treats a fetched all-zero word as end-of-program.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ROM_BYTES = 100,
  parameter int                QDEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_nrd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              issue_valid,
  output logic [INST_W-1:0] issue_inst,
  output logic [ADDR_W-1:0] issue_pc,
  input  logic              issue_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_BYTES) - PC_STEP;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halt_q, halt_d;

  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;
  logic         fetch_ok;
  logic         in_range;
  logic         fetch;
  logic         push;
  logic         pop;
  logic         halt_set;

  assign fetch_ok = !rst && !redirect_valid && !halt_q && !fifo_full;
  assign in_range = (pc_q <= LAST_PC);
  assign fetch    = fetch_ok && in_range;

`ifdef IFU_ZERO_HALT_EN
  logic zero_word;
  assign zero_word = (rom_data == '0);
  assign push      = fetch && !zero_word;
  assign halt_set  = (fetch_ok && !in_range) || (fetch && zero_word);
`else
  assign push      = fetch;
  assign halt_set  = fetch_ok && !in_range;
`endif

  // A redirect discards the head, so the handshake is suppressed in that cycle.
  assign pop = issue_valid && issue_ready && !redirect_valid;

  assign push_entry.inst = rom_data;
  assign push_entry.pc   = pc_q;

  always_comb begin
    pc_d   = pc_q;
    halt_d = halt_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~ADDR_W'(3);
      halt_d = 1'b0;
    end else begin
      if (push) pc_d = pc_q + PC_STEP;
      if (halt_set) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end

  ifu_fifo #(
    .DEPTH   (QDEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign rom_nrd     = !fetch;
  assign rom_addr    = pc_q;
  assign halt        = halt_q;
  assign issue_valid = !fifo_empty;
  assign issue_inst  = issue_valid ? fifo_head.inst : '0;
  assign issue_pc    = issue_valid ? fifo_head.pc : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed test-plan steps then a random phase,
// all compared against a queue-based reference model of the fetch unit.
module tb_inst_fetch_unit;

  localparam int          ROM_BYTES = 100;
  localparam int          QDEPTH    = 4;
  localparam logic [31:0] RESET_PC  = 32'd0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_s;

  logic        clk;
  logic        rst;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        issue_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  logic [7:0]  rom [ROM_BYTES];

  entry_s      mq[$];
  logic [31:0] mpc;
  logic        mhalt;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(
    .ROM_BYTES (ROM_BYTES),
    .QDEPTH    (QDEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_nrd        (rom_nrd),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .issue_valid    (issue_valid),
    .issue_inst     (issue_inst),
    .issue_pc       (issue_pc),
    .issue_ready    (issue_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    int i;
    if (a > 32'(ROM_BYTES - 4)) return 32'h0;
    i = int'(a);
    return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one clock edge of behaviour applied to the current inputs.
  task automatic model_update();
    logic [31:0] w;
    logic        can_try;
    if (rst) begin
      mq.delete();
      mpc   = RESET_PC;
      mhalt = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc   = {redirect_pc[31:2], 2'b00};
      mhalt = 1'b0;
    end else begin
      can_try = !mhalt && (mq.size() < QDEPTH);
      if (mq.size() > 0 && issue_ready) void'(mq.pop_front());
      if (can_try) begin
        if (mpc > 32'(ROM_BYTES - 4)) begin
          mhalt = 1'b1;
        end else begin
          w = rom_word(mpc);
`ifdef IFU_ZERO_HALT_EN
          if (w == 32'h0) begin
            mhalt = 1'b1;
          end else begin
            mq.push_back('{inst: w, pc: mpc});
            mpc = mpc + 32'd4;
          end
`else
          mq.push_back('{inst: w, pc: mpc});
          mpc = mpc + 32'd4;
`endif
        end
      end
    end
  endtask

  task automatic check_output();
    logic        ev;
    logic        fetch;
    ev    = (mq.size() > 0);
    fetch = !rst && !redirect_valid && !mhalt && (mq.size() < QDEPTH)
            && (mpc <= 32'(ROM_BYTES - 4));
    chk("issue_valid", {31'b0, issue_valid}, {31'b0, ev});
    chk("issue_inst", issue_inst, ev ? mq[0].inst : 32'h0);
    chk("issue_pc", issue_pc, ev ? mq[0].pc : 32'h0);
    chk("rom_nrd", {31'b0, rom_nrd}, {31'b0, !fetch});
    chk("rom_addr", rom_addr, mpc);
    chk("halt", {31'b0, halt}, {31'b0, mhalt});
  endtask

  task automatic apply_stimulus(input logic r, input logic rv, input logic [31:0] rp,
                                input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    issue_ready    = rdy;
    #1;
    check_output();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, rdy);
      advance();
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 17);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    issue_ready    = 1'b0;
    mq.delete();
    mpc   = RESET_PC;
    mhalt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state
    do_reset();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset_valid", {31'b0, issue_valid}, 32'h0);
    chk("reset_addr", rom_addr, RESET_PC);
    advance();

    // First instructions, one per cycle
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("first_inst", issue_inst, 32'h00112233);
    chk("first_pc", issue_pc, 32'h0);
    advance();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("second_inst", issue_inst, 32'h44556677);
    chk("second_pc", issue_pc, 32'h4);
    advance();

    // Back-pressure fills the queue and stalls fetch
    do_reset();
    run(10, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_nrd", {31'b0, rom_nrd}, 32'h1);
    chk("stall_head_pc", issue_pc, 32'h0);
    chk("stall_head_inst", issue_inst, 32'h00112233);
    chk("stall_addr", rom_addr, 32'd16);
    advance();

    // Drain to the end of the ROM
    run(40, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("end_halt", {31'b0, halt}, 32'h1);
    chk("end_addr", rom_addr, 32'd100);
    chk("end_valid", {31'b0, issue_valid}, 32'h0);
    advance();

    // Redirect with three entries queued
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0);
    advance();
    run(3, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'h0000002B, 1'b1);
    chk("redir_valid_before", {31'b0, issue_valid}, 32'h1);
    advance();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_empty", {31'b0, issue_valid}, 32'h0);
    chk("redir_addr", rom_addr, 32'h28);
    advance();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_pc", issue_pc, 32'h28);
    advance();

    // Reset mid-stream with two entries queued
    do_reset();
    run(2, 1'b0);
    do_reset();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_mid_valid", {31'b0, issue_valid}, 32'h0);
    chk("rst_mid_addr", rom_addr, RESET_PC);
    advance();

    // Zero word at byte 8
    for (int i = 8; i < 12; i++) rom[i] = 8'h00;
    do_reset();
    run(8, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IFU_ZERO_HALT_EN
    chk("zero_halt", {31'b0, halt}, 32'h1);
    chk("zero_addr", rom_addr, 32'd8);
`else
    chk("zero_nohalt", {31'b0, halt}, 32'h0);
    chk("zero_addr", rom_addr, 32'd32);
`endif
    advance();

    // Random phase
    for (int i = 0; i < ROM_BYTES; i += 4) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 4; j++) rom[i+j] = 8'h00;
      end else begin
        for (int j = 0; j < 4; j++) rom[i+j] = 8'($urandom);
      end
    end
    for (int k = 0; k < 600; k++) begin
      logic r, rv, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rp  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 120));
      apply_stimulus(r, rv, rp, rdy);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
